// File: rtl/serial_tx.sv
// serial_tx: framed, LSB-first bit-serial transmitter with a valid/ready word input.
// Frame: start (0), DATA_W data bits, optional even-parity bit, stop (1).
// Each bit is held on tx for CLKS_PER_BIT cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts the parity bit between data and stop.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = ($clog2(DATA_W + 1) > 1) ? $clog2(DATA_W + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
    ,
    StParity = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nx;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              last_cyc;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign tx       = tx_q;
  assign done     = done_q;

  // Next-state logic; tx_d is the value of tx for the cycle after the coming edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    last_cyc = (cnt_q == LastCnt);
    shift_nx = shift_q >> 1;
`ifdef SERIAL_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (in_valid) begin
          state_d = StStart;
          shift_d = in_data;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      StStart: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (last_cyc) begin
          cnt_d   = '0;
          shift_d = shift_nx;
          bit_d   = bit_q + BitW'(1);
          if (bit_q == LastBit) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_nx[0];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (last_cyc) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StIdle;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    // done is registered, so it is raised on the edge entering the last stop cycle.
    done_d = (state_d == StStop) && (cnt_d == LastCnt);
  end

  // FSM and datapath registers; async reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
